stream_conv3x3: RTL and testbench

STREAM_CONV3X3 -- requirements
Module: stream_conv3x3

---
 rtl/stream_conv3x3.sv | 182 ++++++++++++++++++
 tb/tb_stream_conv3x3.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/stream_conv3x3.sv
// rtl/stream_conv3x3.sv - streaming 3x3 convolution over a raster frame with two line buffers
// Output k is computed when input k+IMG_W+1 (or a flush zero) arrives; out-of-image taps are masked to 0.
module stream_conv3x3 #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 9,
    parameter int SHIFT  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  in_pixel,
    input  logic              coef_load,
    input  logic [3:0]        coef_idx,
    input  logic [COEF_W-1:0] coef_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_pixel,
    output logic              out_last,
    output logic              frame_done
);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int POS_W = $clog2(NPIX + IMG_W + 2);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H + 1);
    localparam int SUM_W = PIX_W + COEF_W + 4;

    localparam logic [POS_W-1:0] POS_FIRST_OUT = POS_W'(IMG_W + 1);
    localparam logic [POS_W-1:0] POS_LAST_IN   = POS_W'(NPIX - 1);
    localparam logic [POS_W-1:0] POS_END       = POS_W'(NPIX + IMG_W + 1);
    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_H - 1);
    localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'((1 << PIX_W) - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                    state;
    logic [POS_W-1:0]          pos;
    logic [COL_W-1:0]          jc;
    logic [COL_W-1:0]          kc;
    logic [ROW_W-1:0]          kr;
    logic signed [COEF_W-1:0]  coef [9];
    logic [PIX_W-1:0]          lb0 [IMG_W];
    logic [PIX_W-1:0]          lb1 [IMG_W];
    logic [PIX_W-1:0]          win [3][2];

    logic                      adv;
    logic                      produce;
    logic [PIX_W-1:0]          npix;
    logic [PIX_W-1:0]          ncol [3];
    logic [PIX_W-1:0]          tap [9];
    logic signed [SUM_W-1:0]   sum;
    logic signed [SUM_W-1:0]   shifted;
    logic signed [SUM_W-1:0]   op_a;
    logic signed [SUM_W-1:0]   op_b;
    logic [PIX_W-1:0]          result;

    assign in_ready = (state == IDLE) || ((state == RUN) && (!out_valid || out_ready));
    assign npix     = (state == FLUSH) ? '0 : in_pixel;
    assign produce  = adv && (pos >= POS_FIRST_OUT);

    always_comb begin
        adv = 1'b0;
        case (state)
            IDLE:    adv = in_valid;
            RUN:     adv = in_valid && in_ready;
            FLUSH:   adv = (pos != POS_END) && (!out_valid || out_ready);
            default: adv = 1'b0;
        endcase
    end

    // New column holds rows (k+1-W, k+1, k+W+1) relative to the output pixel k.
    always_comb begin
        ncol[0] = lb0[jc];
        ncol[1] = lb1[jc];
        ncol[2] = npix;
        for (int r = 0; r < 3; r++) begin
            tap[3*r]     = win[r][0];
            tap[3*r + 1] = win[r][1];
            tap[3*r + 2] = ncol[r];
        end
        if (kr == '0) begin
            tap[0] = '0; tap[1] = '0; tap[2] = '0;
        end
        if (kr == ROW_LAST) begin
            tap[6] = '0; tap[7] = '0; tap[8] = '0;
        end
        if (kc == '0) begin
            tap[0] = '0; tap[3] = '0; tap[6] = '0;
        end
        if (kc == COL_LAST) begin
            tap[2] = '0; tap[5] = '0; tap[8] = '0;
        end
    end

    always_comb begin
        sum  = '0;
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < 9; i++) begin
            op_a = SUM_W'($signed({1'b0, tap[i]}));
            op_b = SUM_W'(coef[i]);
            sum  = sum + op_a * op_b;
        end
        shifted = sum >>> SHIFT;
        if (shifted < 0)
            result = '0;
        else if (shifted > PIX_MAX)
            result = '1;
        else
            result = shifted[PIX_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            lb0[jc] <= lb1[jc];
            lb1[jc] <= npix;
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= ncol[r];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pos        <= '0;
            jc         <= '0;
            kc         <= '0;
            kr         <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_pixel  <= '0;
            frame_done <= 1'b0;
            for (int i = 0; i < 9; i++)
                coef[i] <= (i == 4) ? COEF_W'(1) : '0;
        end else begin
            frame_done <= 1'b0;
            if (state == IDLE && coef_load && coef_idx <= 4'd8)
                coef[coef_idx] <= coef_data;

            if (produce) begin
                out_valid <= 1'b1;
                out_pixel <= result;
                out_last  <= (kr == ROW_LAST) && (kc == COL_LAST);
                if (kc == COL_LAST) begin
                    kc <= '0;
                    kr <= kr + 1'b1;
                end else begin
                    kc <= kc + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            if (adv) begin
                pos <= pos + 1'b1;
                jc  <= (jc == COL_LAST) ? '0 : jc + 1'b1;
            end

            case (state)
                IDLE:  if (adv) state <= RUN;
                RUN:   if (adv && pos == POS_LAST_IN) state <= FLUSH;
                FLUSH: begin
                    if (out_valid && out_ready && out_last) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                        pos        <= '0;
                        jc         <= '0;
                        kc         <= '0;
                        kr         <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_conv3x3.sv
// tb/tb_stream_conv3x3.sv - self-checking bench for stream_conv3x3 against a direct 3x3 reference model
module tb_stream_conv3x3;
    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic       clk = 0;
    logic       reset = 1;
    logic       in_valid = 0;
    logic       in_ready;
    logic [7:0] in_pixel = 0;
    logic       coef_load = 0;
    logic [3:0] coef_idx = 0;
    logic [8:0] coef_data = 0;
    logic       out_valid;
    logic       out_ready = 1;
    logic [7:0] out_pixel;
    logic       out_last;
    logic       frame_done;

    int tests = 0;
    int fails = 0;
    int img [N];
    int kern [9];

    stream_conv3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .COEF_W(9), .SHIFT(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pixel(in_pixel), .coef_load(coef_load), .coef_idx(coef_idx),
        .coef_data(coef_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_pixel(out_pixel), .out_last(out_last), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_out(input int k);
        int r, c, rr, cc, s;
        r = k / W;
        c = k % W;
        s = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr;
                cc = c + dc;
                if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                    s += img[rr*W + cc] * kern[(dr+1)*3 + dc + 1];
            end
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    task automatic set_kern(input int centre, input int other);
        for (int i = 0; i < 9; i++) kern[i] = (i == 4) ? centre : other;
    endtask

    task automatic load_kern();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            coef_load = 1;
            coef_idx  = 4'(i);
            coef_data = 9'(kern[i]);
        end
        @(negedge clk);
        coef_load = 0;
    endtask

    task automatic run_frame(input string name, input int stall, input int rand_valid, input int junk);
        int nin, nout, cyc, hs9, seen, prev_stall, prev_vec, fd_exp;
        nin = 0; nout = 0; cyc = 0; hs9 = -1; seen = 0; prev_stall = 0; prev_vec = 0; fd_exp = 0;
        while (nout < N && cyc < 3000) begin
            @(negedge clk);
            check({name, " frame_done"}, int'(frame_done), fd_exp);
            fd_exp = 0;
            if (prev_stall)
                check({name, " hold"}, int'({out_valid, out_last, out_pixel}), prev_vec);
            if (out_valid && !seen) begin
                seen = 1;
                check({name, " latency"}, cyc, hs9 + 1);
            end
            in_valid  = (nin < N) && (rand_valid ? ($urandom % 2 == 1) : 1'b1);
            in_pixel  = (nin < N) ? 8'(img[nin]) : 8'd0;
            out_ready = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            coef_load = junk && nin >= 2;
            coef_idx  = 4'(cyc % 9);
            coef_data = 9'($urandom);
            #1;
            if (in_valid && in_ready) begin
                if (nin == 9) hs9 = cyc;
                nin++;
            end
            if (out_valid && out_ready) begin
                check({name, " pixel"}, int'(out_pixel), ref_out(nout));
                check({name, " last"}, int'(out_last), int'(nout == N - 1));
                if (out_last) fd_exp = 1;
                nout++;
            end
            prev_stall = out_valid && !out_ready;
            prev_vec   = int'({out_valid, out_last, out_pixel});
            cyc++;
        end
        check({name, " count"}, nout, N);
        @(negedge clk);
        in_valid = 0; coef_load = 0; out_ready = 1;
        check({name, " frame_done end"}, int'(frame_done), fd_exp);
        #1;
        check({name, " idle ready"}, int'(in_ready), 1);
        repeat (3) @(negedge clk);
        check({name, " no extra"}, int'(out_valid), 0);
    endtask

    initial begin
        int cnt;
        @(negedge clk);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_last", int'(out_last), 0);
        check("reset frame_done", int'(frame_done), 0);
        check("reset out_pixel", int'(out_pixel), 0);
        reset = 0;
        #1;
        check("reset in_ready", int'(in_ready), 1);

        set_kern(1, 0);
        for (int i = 0; i < N; i++) img[i] = i;
        run_frame("ramp", 0, 0, 0);

        for (int i = 9; i < 16; i++) begin
            @(negedge clk);
            coef_load = 1; coef_idx = 4'(i); coef_data = 9'h1ff;
        end
        @(negedge clk);
        coef_load = 0;
        run_frame("ramp_junk", 0, 0, 1);

        set_kern(1, 1); load_kern();
        for (int i = 0; i < N; i++) img[i] = 10;
        run_frame("ones10", 0, 0, 0);

        set_kern(8, -1); load_kern();
        run_frame("lap10", 0, 0, 0);

        set_kern(2, 0); load_kern();
        for (int i = 0; i < N; i++) img[i] = 200;
        run_frame("sat200", 0, 0, 0);

        set_kern(1, 1); load_kern();
        for (int i = 0; i < N; i++) img[i] = 0;
        img[3*W + 4] = 255;
        run_frame("spot", 0, 0, 0);

        for (int i = 0; i < 9; i++) kern[i] = $urandom_range(0, 511) - 256;
        load_kern();
        for (int i = 0; i < N; i++) img[i] = $urandom_range(0, 255);
        run_frame("random", 0, 1, 0);

        set_kern(1, 0); load_kern();
        for (int i = 0; i < N; i++) img[i] = i;
        run_frame("stall", 1, 1, 0);

        set_kern(1, 1); load_kern();
        cnt = 0;
        while (cnt < 20) begin
            @(negedge clk);
            in_valid = 1; in_pixel = 8'(img[cnt]); out_ready = 1;
            #1;
            if (in_ready) cnt++;
        end
        @(negedge clk);
        in_valid = 0;
        reset = 1;
        #1;
        check("midreset out_valid", int'(out_valid), 0);
        @(negedge clk);
        reset = 0;
        #1;
        check("midreset in_ready", int'(in_ready), 1);
        check("midreset out_valid2", int'(out_valid), 0);
        set_kern(1, 0);
        run_frame("post_reset", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
